debounce_scan_scheduler: RTL

// - Multi-channel early-acceptance debounce controller: one shared lockout-decrement/compare datapath, time-shared across N_CH noisy inputs.
// - Sits between the raw push-button/switch pins and the FSM/edge-detection logic.
// - A scan tick every TICK_DIV clocks starts a round-robin pass; each channel is serviced in its own slot.
// - A change seen in its slot is accepted immediately (early); that channel then ignores its input for LOCK_TICKS scans.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/debounce_scan_scheduler_if.sv | 23 ++
 rtl/debounce_tick_gen.sv | 29 ++
 rtl/debounce_scan_scheduler.sv | 112 +++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared debounce types and helpers: FSM state encoding and a minimum-one clog2.
// Imported by the scan scheduler and the single-channel debouncers.
package debounce_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StScan = 1'b1
  } state_e;

  localparam state_e ST_IDLE = StIdle;
  localparam state_e ST_SCAN = StScan;

  // Counter width that is never zero, so a 1-value range still gets a 1-bit register.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/debounce_scan_scheduler_if.sv
// Pin-side bundle of the scan debouncer; pulse signals exist only with DEBOUNCE_EDGE_EN.
// master = debouncer side, slave = consumer side.
interface debounce_scan_scheduler_if #(
  parameter int unsigned N_CH = 4
);

  logic [N_CH-1:0] noisy_in;
  logic [N_CH-1:0] db_out;
  logic            busy;
`ifdef DEBOUNCE_EDGE_EN
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;

  modport master (input noisy_in, output db_out, output busy,
                  output rise_pulse, output fall_pulse);
  modport slave  (output noisy_in, input db_out, input busy,
                  input rise_pulse, input fall_pulse);
`else
  modport master (input noisy_in, output db_out, output busy);
  modport slave  (output noisy_in, input db_out, input busy);
`endif

endinterface

// File: rtl/debounce_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and asserts tick_o for one cycle at the top.
module debounce_tick_gen
  import debounce_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned CntW = clog2_min1(TICK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntW'(TICK_DIV - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debounce_scan_scheduler.sv
// Time-shared early-acceptance debouncer: one lockout/compare datapath walks all channels
// once per scan tick. DEBOUNCE_EDGE_EN adds registered rise/fall pulses.
module debounce_scan_scheduler
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TICK_DIV   = 100_000,
  parameter int unsigned LOCK_TICKS = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  debounce_scan_scheduler_if.master   bus
);

  localparam int unsigned LockW = clog2_min1(LOCK_TICKS + 1);
  localparam int unsigned PtrW  = clog2_min1(N_CH);

  logic                  tick;
  logic [N_CH-1:0]       sync1_q, sync2_q;
  logic [N_CH-1:0]       db_q, db_d;
  state_e                state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [LockW-1:0]      lock_q [N_CH];
  logic [LockW-1:0]      lock_d [N_CH];
`ifdef DEBOUNCE_EDGE_EN
  logic [N_CH-1:0]       rise_q, rise_d, fall_q, fall_d;
`endif

  debounce_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    db_d    = db_q;
    lock_d  = lock_q;
`ifdef DEBOUNCE_EDGE_EN
    rise_d  = '0;
    fall_d  = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StScan;
          ptr_d   = '0;
        end
      end
      StScan: begin
        if (ptr_q == PtrW'(N_CH - 1)) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
        // Only the slot owner is touched; a locked channel just burns one scan of lockout.
        for (int k = 0; k < N_CH; k++) begin
          if (ptr_q == PtrW'(k)) begin
            if (lock_q[k] != '0) begin
              lock_d[k] = lock_q[k] - 1'b1;
            end else if (sync2_q[k] != db_q[k]) begin
              db_d[k]   = sync2_q[k];
              lock_d[k] = LockW'(LOCK_TICKS);
`ifdef DEBOUNCE_EDGE_EN
              rise_d[k] = sync2_q[k];
              fall_d[k] = ~sync2_q[k];
`endif
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      state_q <= StIdle;
      ptr_q   <= '0;
      lock_q  <= '{default: '0};
`ifdef DEBOUNCE_EDGE_EN
      rise_q  <= '0;
      fall_q  <= '0;
`endif
    end else begin
      sync1_q <= bus.noisy_in;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
`ifdef DEBOUNCE_EDGE_EN
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`endif
    end
  end

  assign bus.db_out = db_q;
  assign bus.busy   = (state_q == StScan);
`ifdef DEBOUNCE_EDGE_EN
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
`endif

endmodule
